router_fifo: RTL

ROUTER_FIFO -- requirements
Module: router_fifo

---
 rtl/router_pkg.sv | 11 +
 rtl/router_fifo.sv | 95 +++++++++
 2 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: default FIFO geometry and the header length
// field position used by the packet counter.
package router_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_DEPTH   = 16;
    localparam int HDR_LEN_MSB = 7;
    localparam int HDR_LEN_LSB = 2;
    localparam int PKT_CNT_W   = 7;

endpackage

// File: rtl/router_fifo.sv
// Router output FIFO: stores bytes tagged with a header flag, and tracks the
// remaining packet length so dataout drops to zero once a packet has drained.
module router_fifo
    import router_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] datain,
    input  logic             read_enb,
    output logic [WIDTH-1:0] dataout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH:0]         mem_q [DEPTH];
    logic [AW:0]            wrPtr_q, wrPtr_d;
    logic [AW:0]            rdPtr_q, rdPtr_d;
    logic [PKT_CNT_W-1:0]   pktCnt_q, pktCnt_d;
    logic [WIDTH-1:0]       dataout_q, dataout_d;
    logic [WIDTH:0]         rdEntry;
    logic                   wrAccept;
    logic                   rdAccept;

    // Pointer MSB is a wrap bit, so equal pointers mean empty and a differing
    // MSB with equal low bits means full.
    assign empty    = (wrPtr_q == rdPtr_q);
    assign full     = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                      (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign rdEntry  = mem_q[rdPtr_q[AW-1:0]];
    assign wrAccept = write_enb && !full && !soft_reset;
    assign rdAccept = read_enb && !empty && !soft_reset;
    assign dataout  = dataout_q;

    always_comb begin
        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        pktCnt_d  = pktCnt_q;
        dataout_d = dataout_q;
        if (soft_reset) begin
            wrPtr_d   = '0;
            rdPtr_d   = '0;
            pktCnt_d  = '0;
            dataout_d = '0;
        end else begin
            if (wrAccept) begin
                wrPtr_d = wrPtr_q + (AW+1)'(1);
            end
            if (rdAccept) begin
                rdPtr_d   = rdPtr_q + (AW+1)'(1);
                dataout_d = rdEntry[WIDTH-1:0];
                // Header carries payload length; the extra count covers parity.
                if (rdEntry[WIDTH]) begin
                    pktCnt_d = PKT_CNT_W'(rdEntry[HDR_LEN_MSB:HDR_LEN_LSB]) + PKT_CNT_W'(1);
                end else if (pktCnt_q != '0) begin
                    pktCnt_d = pktCnt_q - PKT_CNT_W'(1);
                end
            end else if (pktCnt_q == '0) begin
                dataout_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            pktCnt_q  <= '0;
            dataout_q <= '0;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            pktCnt_q  <= pktCnt_d;
            dataout_q <= dataout_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (soft_reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wrAccept) begin
            mem_q[wrPtr_q[AW-1:0]] <= {lfd_state, datain};
        end
    end

endmodule
